// File: rtl/tl_branch_predictor_param_if.sv
// Request / prediction / resolve bundle of the parametrised two-level predictor.
// The master modport drives requests and outcomes, the slave modport is the predictor.
`timescale 1ns/1ps
interface tl_branch_predictor_param_if #(
  parameter int IP_WIDTH  = 64,
  parameter int INFLIGHT  = 4,
  parameter int CNT_WIDTH = 32
);
  logic                        req_valid;
  logic [IP_WIDTH-1:0]         req_ip;
  logic                        req_ready;
  logic                        pred_valid;
  logic                        prediction;
  logic                        upd_valid;
  logic                        upd_taken;
  logic [$clog2(INFLIGHT):0]   inflight_cnt;
  logic [CNT_WIDTH-1:0]        branch_cnt;
  logic [CNT_WIDTH-1:0]        mispredict_cnt;
  logic                        upd_err;

  modport master (
    output req_valid, req_ip, upd_valid, upd_taken,
    input  req_ready, pred_valid, prediction, inflight_cnt,
           branch_cnt, mispredict_cnt, upd_err
  );

  modport slave (
    input  req_valid, req_ip, upd_valid, upd_taken,
    output req_ready, pred_valid, prediction, inflight_cnt,
           branch_cnt, mispredict_cnt, upd_err
  );
endinterface

// File: rtl/tl_branch_predictor_param.sv
// Parametrised two-level branch predictor (GAg / gshare / GAp) with an in-flight
// resolve queue, non-speculative global history and saturating statistics.
`timescale 1ns/1ps
module tl_branch_predictor_param #(
  parameter int IP_WIDTH  = 64,
  parameter int GHR_BITS  = 8,
  parameter int PC_BITS   = 8,
  parameter int MODE      = 1,
  parameter int CTR_BITS  = 2,
  parameter int INFLIGHT  = 4,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  tl_branch_predictor_param_if.slave bus
);

  localparam int IDX   = (MODE == 2) ? PC_BITS + GHR_BITS : GHR_BITS;
  localparam int DEPTH = 1 << IDX;
  localparam int PTR_W = $clog2(INFLIGHT);
  localparam int IP_W  = IP_WIDTH;

  localparam logic [CTR_BITS-1:0]  CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [PTR_W:0]       FULL     = (PTR_W + 1)'(INFLIGHT);
  localparam logic [CNT_WIDTH-1:0] STAT_MAX = '1;

  typedef struct packed {
    logic [IDX-1:0] idx;
    logic           pred;
  } entry_t;

  logic [CTR_BITS-1:0]  pht_q  [DEPTH];
  entry_t               fifo_q [INFLIGHT];
  logic [GHR_BITS-1:0]  ghr_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       cnt_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;
  logic                 pred_valid_q, prediction_q, upd_err_q;

  logic [IP_W-1:0]      ip;
  logic [IDX-1:0]       req_idx;
  logic                 accept, pop, pred_bit;
  entry_t               oldest;
  logic [CTR_BITS-1:0]  ctr_cur, ctr_d;
  logic [PTR_W:0]       cnt_d;
  logic [GHR_BITS-1:0]  ghr_d;

  assign ip = bus.req_ip;

  // History is the committed ghr only; requests behind unresolved branches see stale history.
  if (MODE == 2) begin : g_gap
    assign req_idx = {ip[PC_BITS-1:0], ghr_q};
  end else if (MODE == 1) begin : g_gshare
    assign req_idx = ghr_q ^ ip[GHR_BITS-1:0];
  end else begin : g_gag
    assign req_idx = ghr_q;
  end

  assign accept   = bus.req_valid && (cnt_q < FULL);
  assign pop      = bus.upd_valid && (cnt_q != '0);
  assign pred_bit = pht_q[req_idx][CTR_BITS-1];
  assign oldest   = fifo_q[rd_ptr_q];
  assign ctr_cur  = pht_q[oldest.idx];
  assign ghr_d    = {ghr_q[GHR_BITS-2:0], bus.upd_taken};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ctr_d = ctr_cur;
    if (bus.upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_BITS'(1);
    end else if (ctr_cur != '0) begin
      ctr_d = ctr_cur - CTR_BITS'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + (PTR_W + 1)'(1);
    else if (pop && !accept) cnt_d = cnt_q - (PTR_W + 1)'(1);
  end

  // NOTE: queue payload has no reset; cnt_q and the pointers guarantee it is never read before written.
  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q] <= {req_idx, pred_bit};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CTR_INIT;
      ghr_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      cnt_q            <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      pred_valid_q     <= 1'b0;
      prediction_q     <= 1'b0;
      upd_err_q        <= 1'b0;
    end else begin
      pred_valid_q <= accept;
      cnt_q        <= cnt_d;
      if (accept) begin
        prediction_q <= pred_bit;
        wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        pht_q[oldest.idx] <= ctr_d;
        ghr_q             <= ghr_d;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
        if (branch_cnt_q != STAT_MAX) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
        if ((oldest.pred != bus.upd_taken) && (mispredict_cnt_q != STAT_MAX))
          mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
      end
      if (bus.upd_valid && !pop) upd_err_q <= 1'b1;
    end
  end

  assign bus.req_ready      = (cnt_q < FULL);
  assign bus.pred_valid     = pred_valid_q;
  assign bus.prediction     = prediction_q;
  assign bus.inflight_cnt   = cnt_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;
  assign bus.upd_err        = upd_err_q;

endmodule

// File: doc/tl_branch_predictor_param.md
Name: tl_branch_predictor_param

Overview:
- Parametrised successor of the current fixed two-level predictor.
- Indexing mode is selectable: GAg, gshare or GAp.
- A request/resolve handshake is backed by an in-flight queue, so outcomes may arrive several branches late.
- Built-in branch and misprediction statistics counters replace the bench-side counting.

Parameters:
IP_WIDTH, 64, instruction pointer width
GHR_BITS, 8, global history length in bits
PC_BITS, 8, ip bits concatenated in GAp mode
MODE, 1, 0=GAg (idx=ghr), 1=gshare (idx=ghr^ip[GHR_BITS-1:0]), 2=GAp (idx={ip[PC_BITS-1:0],ghr})
CTR_BITS, 2, saturating counter width
INFLIGHT, 4, max unresolved predictions (power of 2, >=2)
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  prediction request
req_ip  in  IP_WIDTH  branch ip
req_ready  out  1  queue not full
pred_valid  out  1  prediction result valid
prediction  out  1  1=taken, 0=not taken
upd_valid  in  1  resolve oldest in-flight branch
upd_taken  in  1  actual outcome
inflight_cnt  out  $clog2(INFLIGHT)+1  unresolved predictions
branch_cnt  out  CNT_WIDTH  resolved branches
mispredict_cnt  out  CNT_WIDTH  resolved mispredictions
upd_err  out  1  sticky: update arrived with empty queue

Behaviour:
- Reset (asynchronous, any time) clears all state:
  - PHT entries = weakly not-taken, value 2^(CTR_BITS-1)-1 (01 for 2 bits).
  - ghr=0; queue empty; inflight_cnt=0; branch_cnt=0; mispredict_cnt=0; upd_err=0.
  - pred_valid=0, prediction=0, req_ready=1.
  - In-flight entries are discarded, not resolved.
- PHT:
  - Depth 2^IDX, where IDX = GHR_BITS for MODE 0/1 and PC_BITS+GHR_BITS for MODE 2.
  - Predicted direction = counter MSB.
- Request accept: req_valid & req_ready at edge N.
  - Index computed from req_ip and the committed ghr before edge N.
  - At N+1: pred_valid=1 for exactly one cycle; prediction = MSB of that PHT entry.
  - The {index, predicted bit} pair is pushed into the queue.
  - No request accepted -> pred_valid=0; prediction holds its last value.
- Latency: 1 cycle, request to prediction. Throughput: 1 per cycle while req_ready=1.
- req_ready = (inflight_cnt < INFLIGHT), a registered-count compare.
  - A pop in the cycle the queue is full raises req_ready at the next cycle, not combinationally.
- Update: upd_valid at edge M with queue non-empty pops the oldest entry.
  - Counter at the stored index: +1 if taken, -1 if not; saturates at 0 and 2^CTR_BITS-1.
  - ghr <= {ghr[GHR_BITS-2:0], upd_taken}.
  - branch_cnt +1.
  - mispredict_cnt +1 if stored predicted bit != upd_taken.
  - Both statistics counters saturate at all-ones.
- Update with empty queue: no state change except upd_err <= 1, which is sticky until reset.
- Ghr is non-speculative: requests issued while others are unresolved use stale history. This is intended.
- Same-cycle request and update:
  - Both are performed.
  - The request sees the pre-update ghr and pre-update PHT contents.
  - inflight_cnt is unchanged.
  - A request at full is not accepted even when an update occurs in the same cycle.
- Queue pointers wrap modulo INFLIGHT.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then req ip=5 -> next cycle pred_valid=1, prediction=0, inflight_cnt=1, req_ready=1.
2. MODE=0, GHR_BITS=2, always-taken branch, each request followed by its update, 4 times -> predictions 0,0,0,1 (indices 0,1,3,3); ghr=11; branch_cnt=4; mispredict_cnt=3; PHT[3]=11.
3. INFLIGHT=4: four back-to-back requests, no updates -> req_ready=0 after the 4th accept; 5th request held with no pred_valid; one update -> req_ready=1 the following cycle; 5th accepted; inflight_cnt=4.
4. upd_valid=1 with empty queue -> upd_err=1; branch_cnt, ghr and PHT unchanged; upd_err stays 1 through later normal traffic until reset.
5. MODE=1, GHR_BITS=2, ghr=01, req ip=3 -> index 2 used (check via the pushed entry / updated counter). Counter at 11 updated taken stays 11; at 00 updated not-taken stays 00.
6. Reset asserted mid-cycle with 2 in flight -> all outputs cleared immediately; a later update sets upd_err=1; the next request predicts 0.
